// File: rtl/rx_timing_probe_ctrl.sv
// rx_timing_probe_ctrl
// Runs a series of TX-to-RX latency probes against the RX timing checker.
// Each probe pulses tx_start, raises tx_started_req, and then waits until
// both the checker's result beat and its ack have been seen. It then drops
// req and waits for the ack to fall. The latency in the top 48 bits of the
// result beat feeds the last/min/max/sum statistics. A probe that times out
// aborts the remaining run. All outputs are registered.

module rx_timing_probe_ctrl #(
   parameter int AXIS_DATA_WIDTH = 512,
   parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH/8,
   parameter int TIMEOUT_CYCLES  = 1000000
) (
   input  logic                       clk,
   input  logic                       areset,
   input  logic                       start,
   input  logic [15:0]                num_probes,
   input  logic [31:0]                gap_cycles,
   output logic                       tx_start,
   output logic                       tx_started_req,
   input  logic                       tx_started_ack,
   input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                       s_axis_tvalid,
   output logic                       s_axis_tready,
   input  logic                       s_axis_tlast,
   output logic                       busy,
   output logic                       done,
   output logic                       timeout_err,
   output logic [15:0]                probe_count,
   output logic [47:0]                last_latency,
   output logic [47:0]                min_latency,
   output logic [47:0]                max_latency,
   output logic [63:0]                sum_latency
);

   localparam int LAT_W = 48;
   // The timeout counter only has to reach TIMEOUT_CYCLES-1.
   localparam int TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_WAIT,
      S_REL,
      S_GAP,
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_next;

   logic [15:0]         r_num;        // probes requested for this run
   logic [31:0]         r_gap;        // gap length for this run
   logic [15:0]         r_idx;        // index of the probe in flight
   logic [TMO_W-1:0]    r_tmo_cnt;    // cycles spent in the current WAIT
   logic [31:0]         r_gap_cnt;    // cycles spent in the current GAP
   logic                r_beat_seen;  // result beat already taken this probe
   logic                r_ack_seen;   // ack already observed this probe

   logic                w_start_acc;
   logic                w_accept;
   logic [LAT_W-1:0]    w_lat;
   logic                w_beat_ok;
   logic                w_ack_ok;
   logic                w_resp_done;
   logic                w_tmo;
   logic                w_tmo_exit;
   logic                w_last_probe;
   logic                w_gap_done;
   logic                w_unused;

   // tkeep, tlast and the low data bits carry nothing this block needs.
   assign w_unused = &{1'b0, s_axis_tkeep, s_axis_tlast,
                       s_axis_tdata[AXIS_DATA_WIDTH-LAT_W-1:0]};

   assign w_start_acc  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_accept     = (r_state == S_WAIT) && s_axis_tready && s_axis_tvalid;
   assign w_lat        = s_axis_tdata[AXIS_DATA_WIDTH-1 -: LAT_W];

   // The beat and the ack may arrive in either order, or together; the
   // current-cycle terms let the probe finish in the cycle the second one lands.
   assign w_beat_ok    = r_beat_seen || w_accept;
   assign w_ack_ok     = r_ack_seen || tx_started_ack;
   assign w_resp_done  = w_beat_ok && w_ack_ok;
   assign w_tmo        = (r_tmo_cnt == TMO_LAST);
   assign w_tmo_exit   = (r_state == S_WAIT) && !w_resp_done && w_tmo;

   assign w_last_probe = (({1'b0, r_idx} + 17'd1) == {1'b0, r_num});
   // A zero gap still spends one cycle in GAP before re-arming.
   assign w_gap_done   = (({1'b0, r_gap_cnt} + 33'd1) >= {1'b0, r_gap});

   // State register
   always_ff @(posedge clk or posedge areset) begin
      if (areset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) w_next = (num_probes == 16'd0) ? S_DONE : S_ARM;
         end
         S_ARM:  w_next = S_WAIT;
         S_WAIT: begin
            if (w_resp_done || w_tmo) w_next = S_REL;
         end
         S_REL: begin
            if (!tx_started_ack)
               w_next = (w_last_probe || timeout_err) ? S_DONE : S_GAP;
         end
         S_GAP: begin
            if (w_gap_done) w_next = S_ARM;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Handshake and status outputs, registered from the next state
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         tx_start       <= 1'b0;
         tx_started_req <= 1'b0;
         s_axis_tready  <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         tx_start       <= (w_next == S_ARM);
         tx_started_req <= (w_next == S_ARM) || (w_next == S_WAIT);
         // Ready only while waiting, and only until the first beat is taken.
         s_axis_tready  <= (w_next == S_WAIT) &&
                           !((r_state == S_WAIT) && w_beat_ok);
         busy           <= (w_next == S_ARM) || (w_next == S_WAIT) ||
                           (w_next == S_REL) || (w_next == S_GAP);
         done           <= (w_next == S_DONE);
      end
   end

   // Run configuration latched at an accepted start
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         r_num <= 16'd0;
         r_gap <= 32'd0;
      end else if (w_start_acc) begin
         r_num <= num_probes;
         r_gap <= gap_cycles;
      end
   end

   // Probe index, advanced each time a probe is released into GAP
   always_ff @(posedge clk or posedge areset) begin
      if (areset)                               r_idx <= 16'd0;
      else if (w_start_acc)                     r_idx <= 16'd0;
      else if ((r_state == S_REL) && (w_next == S_GAP)) r_idx <= r_idx + 16'd1;
   end

   // Timeout counter, restarts from 0 on every entry to WAIT
   always_ff @(posedge clk or posedge areset) begin
      if (areset)                 r_tmo_cnt <= '0;
      else if (r_state == S_WAIT) r_tmo_cnt <= r_tmo_cnt + 1'b1;
      else                        r_tmo_cnt <= '0;
   end

   // Gap counter, restarts from 0 on every entry to GAP
   always_ff @(posedge clk or posedge areset) begin
      if (areset)                r_gap_cnt <= 32'd0;
      else if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt + 32'd1;
      else                       r_gap_cnt <= 32'd0;
   end

   // Per-probe record of which response events have been observed
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         r_beat_seen <= 1'b0;
         r_ack_seen  <= 1'b0;
      end else if (r_state == S_WAIT) begin
         if (w_accept)       r_beat_seen <= 1'b1;
         if (tx_started_ack) r_ack_seen  <= 1'b1;
      end else begin
         r_beat_seen <= 1'b0;
         r_ack_seen  <= 1'b0;
      end
   end

   // Sticky timeout flag, cleared at each accepted start
   always_ff @(posedge clk or posedge areset) begin
      if (areset)           timeout_err <= 1'b0;
      else if (w_start_acc) timeout_err <= 1'b0;
      else if (w_tmo_exit)  timeout_err <= 1'b1;
   end

   // Latency statistics, updated once per accepted result beat
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         probe_count  <= 16'd0;
         last_latency <= '0;
         min_latency  <= '0;
         max_latency  <= '0;
         sum_latency  <= 64'd0;
      end else if (w_start_acc) begin
         probe_count  <= 16'd0;
         last_latency <= '0;
         min_latency  <= '1;
         max_latency  <= '0;
         sum_latency  <= 64'd0;
      end else if (w_accept) begin
         probe_count  <= probe_count + 16'd1;
         last_latency <= w_lat;
         sum_latency  <= sum_latency + {16'd0, w_lat};
         if (w_lat < min_latency) min_latency <= w_lat;
         if (w_lat > max_latency) max_latency <= w_lat;
      end
   end

endmodule

// File: tb/tb_rx_timing_probe_ctrl.sv
// Bench for rx_timing_probe_ctrl: a table of hand-derived runs, a few
// hand-written corner sequences, then random runs scored by a queue model.
module tb_rx_timing_probe_ctrl;
   localparam int DW  = 512;
   localparam int KW  = DW/8;
   localparam int TMO = 16;

   logic           clk = 1'b0;
   logic           areset;
   logic           start = 1'b0;
   logic [15:0]    num_probes = '0;
   logic [31:0]    gap_cycles = '0;
   logic           tx_start, tx_started_req;
   logic           tx_started_ack = 1'b0;
   logic [DW-1:0]  s_axis_tdata = '0;
   logic [KW-1:0]  s_axis_tkeep = '1;
   logic           s_axis_tvalid = 1'b0;
   logic           s_axis_tready;
   logic           s_axis_tlast = 1'b1;
   logic           busy, done, timeout_err;
   logic [15:0]    probe_count;
   logic [47:0]    last_latency, min_latency, max_latency;
   logic [63:0]    sum_latency;

   int errors = 0;
   int checks = 0;

   rx_timing_probe_ctrl #(
      .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .areset(areset), .start(start), .num_probes(num_probes),
      .gap_cycles(gap_cycles), .tx_start(tx_start), .tx_started_req(tx_started_req),
      .tx_started_ack(tx_started_ack), .s_axis_tdata(s_axis_tdata),
      .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .busy(busy),
      .done(done), .timeout_err(timeout_err), .probe_count(probe_count),
      .last_latency(last_latency), .min_latency(min_latency),
      .max_latency(max_latency), .sum_latency(sum_latency)
   );

   always #5 clk = ~clk;

   // tx_start must never be high on two consecutive cycles
   logic prev_tx = 1'b0;
   logic dbl_tx  = 1'b0;
   always @(negedge clk) begin
      dbl_tx  <= dbl_tx | (tx_start & prev_tx);
      prev_tx <= tx_start;
   end

   typedef struct {
      int               num;
      int               gap;
      bit               stray;
      logic [3:0]       resp;
      logic [3:0][47:0] lat;
      logic [3:0][7:0]  ackd;
      logic [3:0][7:0]  beatd;
      logic [3:0][7:0]  reld;
      logic [15:0]      e_cnt;
      logic [47:0]      e_last, e_min, e_max;
      logic [63:0]      e_sum;
      logic             e_tmo;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] mk_beat(input logic [47:0] lat);
      logic [DW-1:0] d;
      for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom();
      d[DW-1 -: 48] = lat;
      return d;
   endfunction

   // Reference: the run captures each probe's latency until the first
   // unanswered probe, which aborts the run with a timeout.
   function automatic vec_t model(input vec_t v);
      vec_t        r;
      logic [47:0] got[$];
      logic [47:0] srt[$];
      r = v;
      r.e_tmo = 1'b0;
      for (int i = 0; i < v.num; i++) begin
         if (!v.resp[i]) begin r.e_tmo = 1'b1; break; end
         got.push_back(v.lat[i]);
      end
      r.e_cnt = 16'(got.size());
      r.e_sum = 64'd0;
      foreach (got[k]) r.e_sum = r.e_sum + 64'(got[k]);
      srt = got;
      srt.sort();
      r.e_min  = (got.size() > 0) ? srt[0] : 48'hFFFF_FFFF_FFFF;
      r.e_max  = (got.size() > 0) ? srt[$] : 48'd0;
      r.e_last = (got.size() > 0) ? got[$] : 48'd0;
      return r;
   endfunction

   // Wait for one probe's tx_start, then play the checker for it.
   task automatic serve_probe(input string tag, input int exp_gap, input int ackd,
                              input int beatd, input logic [47:0] lat, input bit resp,
                              input int reld, input bit stray);
      int n = 0, cyc = 0, exp_exit;
      bit got = 0, hs, rel_bad = 0;
      while (!tx_start && n < 200) begin
         if (stray) begin
            chk({tag, ".tready_idle"}, s_axis_tready, 0);
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = mk_beat(48'h1234_5678_9ABC);
            if (n == 1) begin start = 1'b1; num_probes = 16'd7; end
            else start = 1'b0;
         end
         @(negedge clk); n++;
      end
      start = 1'b0;
      s_axis_tvalid = 1'b0;
      chk({tag, ".tx_start_seen"}, (n < 200), 1);
      if (exp_gap >= 0) chk({tag, ".gap_len"}, n, ((exp_gap < 1) ? 1 : exp_gap) + 1);
      exp_exit = resp ? (((beatd > ackd) ? beatd : ackd) < 1 ? 1 : ((beatd > ackd) ? beatd : ackd)) + 1
                      : TMO + 1;
      while (tx_started_req && cyc < 100) begin
         if (resp && cyc >= ackd) tx_started_ack = 1'b1;
         if (resp && !got && cyc >= beatd) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = mk_beat(lat);
         end
         hs = s_axis_tvalid && s_axis_tready;
         @(negedge clk); cyc++;
         if (hs) begin
            got = 1;
            // offer a second, different beat that must be refused
            s_axis_tdata = mk_beat(~lat);
            if (tx_started_req) chk({tag, ".tready_drop"}, s_axis_tready, 0);
         end
      end
      s_axis_tvalid = 1'b0;
      chk({tag, ".req_drop_cycle"}, cyc, exp_exit);
      if (resp) begin
         for (int i = 0; i < reld; i++) begin
            if (done || tx_start || tx_started_req) rel_bad = 1;
            @(negedge clk);
         end
         chk({tag, ".held_in_release"}, rel_bad, 0);
         tx_started_ack = 1'b0;
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int w = 0;
      bit bad = 0;
      @(negedge clk);
      num_probes = 16'(v.num); gap_cycles = 32'(v.gap); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (v.num == 0) begin
         chk({tag, ".done_next"}, done, 1);
         for (int i = 0; i < 8; i++) begin
            if (busy || tx_start || tx_started_req) bad = 1;
            @(negedge clk);
         end
         chk({tag, ".quiet"}, bad, 0);
      end else begin
         chk({tag, ".busy"}, busy, 1);
         chk({tag, ".done_clr"}, done, 0);
         for (int i = 0; i < v.num; i++) begin
            serve_probe(tag, (i == 0) ? -1 : v.gap, v.ackd[i], v.beatd[i], v.lat[i],
                        v.resp[i], v.reld[i], v.stray && (i > 0));
            if (!v.resp[i]) break;
         end
         while (!done && w < 50) begin @(negedge clk); w++; end
         chk({tag, ".done"}, done, 1);
         chk({tag, ".busy_end"}, busy, 0);
      end
      chk({tag, ".count"}, probe_count, v.e_cnt);
      chk({tag, ".last"}, last_latency, v.e_last);
      chk({tag, ".min"}, min_latency, v.e_min);
      chk({tag, ".max"}, max_latency, v.e_max);
      chk({tag, ".sum"}, sum_latency, v.e_sum);
      chk({tag, ".tmo"}, timeout_err, v.e_tmo);
      chk({tag, ".tx_single"}, dbl_tx, 0);
   endtask

   function automatic vec_t blank(input int num, input int gap);
      vec_t v;
      v.num = num; v.gap = gap; v.stray = 0; v.resp = 4'b1111;
      v.lat = '0; v.ackd = '0; v.beatd = '0; v.reld = '0;
      v.e_cnt = 0; v.e_last = 0; v.e_min = 48'hFFFF_FFFF_FFFF; v.e_max = 0;
      v.e_sum = 0; v.e_tmo = 0;
      return v;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      vec_t v;
      logic [63:0] rr;

      // basic 3-probe run
      tbl[0] = blank(3, 5);
      tbl[0].lat[0] = 100; tbl[0].lat[1] = 40;  tbl[0].lat[2] = 250;
      tbl[0].ackd[0] = 2;  tbl[0].ackd[1] = 0;  tbl[0].ackd[2] = 3;
      tbl[0].beatd[0] = 1; tbl[0].beatd[1] = 2; tbl[0].beatd[2] = 1;
      tbl[0].reld[0] = 1;  tbl[0].reld[1] = 0;  tbl[0].reld[2] = 2;
      tbl[0].e_cnt = 3; tbl[0].e_last = 250; tbl[0].e_min = 40; tbl[0].e_max = 250; tbl[0].e_sum = 390;
      // ack 3 cycles before beat, then beat before ack; ack held into release
      tbl[1] = blank(2, 0);
      tbl[1].lat[0] = 7;   tbl[1].lat[1] = 9;
      tbl[1].ackd[0] = 1;  tbl[1].beatd[0] = 4;
      tbl[1].ackd[1] = 5;  tbl[1].beatd[1] = 1;
      tbl[1].reld[0] = 3;  tbl[1].reld[1] = 3;
      tbl[1].e_cnt = 2; tbl[1].e_last = 9; tbl[1].e_min = 7; tbl[1].e_max = 9; tbl[1].e_sum = 16;
      // checker never answers the first probe
      tbl[2] = blank(2, 3);
      tbl[2].resp = 4'b1110; tbl[2].e_tmo = 1;
      // empty run
      tbl[3] = blank(0, 2);
      // equal latencies leave min/max alone
      tbl[4] = blank(3, 1);
      tbl[4].lat[0] = 70; tbl[4].lat[1] = 70; tbl[4].lat[2] = 70;
      tbl[4].beatd[0] = 1; tbl[4].beatd[1] = 1; tbl[4].beatd[2] = 1;
      tbl[4].e_cnt = 3; tbl[4].e_last = 70; tbl[4].e_min = 70; tbl[4].e_max = 70; tbl[4].e_sum = 210;
      // extreme latency values
      tbl[5] = blank(2, 2);
      tbl[5].lat[0] = 48'hFFFF_FFFF_FFFF; tbl[5].lat[1] = 0;
      tbl[5].ackd[0] = 1; tbl[5].beatd[1] = 2;
      tbl[5].e_cnt = 2; tbl[5].e_last = 0; tbl[5].e_min = 0;
      tbl[5].e_max = 48'hFFFF_FFFF_FFFF; tbl[5].e_sum = 64'h0000_FFFF_FFFF_FFFF;
      // timeout in the middle aborts the rest of the run
      tbl[6] = blank(3, 2);
      tbl[6].resp = 4'b1101; tbl[6].lat[0] = 77; tbl[6].lat[2] = 99;
      tbl[6].beatd[0] = 2; tbl[6].ackd[0] = 2;
      tbl[6].e_cnt = 1; tbl[6].e_last = 77; tbl[6].e_min = 77; tbl[6].e_max = 77;
      tbl[6].e_sum = 77; tbl[6].e_tmo = 1;
      // stray start pulse and stray beat during the gap
      tbl[7] = blank(2, 6);
      tbl[7].stray = 1; tbl[7].lat[0] = 300; tbl[7].lat[1] = 200;
      tbl[7].ackd[0] = 1; tbl[7].beatd[1] = 3; tbl[7].reld[0] = 1;
      tbl[7].e_cnt = 2; tbl[7].e_last = 200; tbl[7].e_min = 200; tbl[7].e_max = 300; tbl[7].e_sum = 500;

      // reset state
      areset = 1'b1;
      #1;
      chk("rst.tx_start", tx_start, 0);
      chk("rst.req", tx_started_req, 0);
      chk("rst.tready", s_axis_tready, 0);
      chk("rst.busy_done", {busy, done, timeout_err}, 0);
      chk("rst.stats", {probe_count, last_latency, min_latency, max_latency} | 64'(sum_latency), 0);
      repeat (2) @(negedge clk);
      areset = 1'b0;

      for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

      // asynchronous reset in the middle of a WAIT with req high
      @(negedge clk);
      num_probes = 16'd2; gap_cycles = 32'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      serve_probe("arst.p0", -1, 1, 1, 48'd500, 1'b1, 0, 1'b0);
      w = 0;
      while (!tx_start && w < 50) begin @(negedge clk); w++; end
      repeat (3) @(negedge clk);
      chk("arst.req_before", tx_started_req, 1);
      chk("arst.count_before", probe_count, 1);
      #2 areset = 1'b1;
      #1;
      chk("arst.req", tx_started_req, 0);
      chk("arst.tx_tready", {tx_start, s_axis_tready}, 0);
      chk("arst.flags", {busy, done, timeout_err}, 0);
      chk("arst.count", probe_count, 0);
      chk("arst.min", min_latency, 0);
      chk("arst.sum_last_max", sum_latency | 64'(last_latency) | 64'(max_latency), 0);
      @(negedge clk);
      areset = 1'b0;
      v = blank(2, 1);
      v.lat[0] = 11; v.lat[1] = 5; v.beatd[0] = 1; v.ackd[1] = 2;
      run_vec(model(v), "arst.rerun");

      // random runs scored by the model
      for (int r = 0; r < 12; r++) begin
         v = blank($urandom_range(0, 4), $urandom_range(0, 4));
         v.stray = 1'($urandom_range(0, 1));
         for (int p = 0; p < 4; p++) begin
            v.resp[p]  = ($urandom_range(0, 7) != 0);
            v.ackd[p]  = 8'($urandom_range(0, 6));
            v.beatd[p] = 8'($urandom_range(0, 6));
            v.reld[p]  = 8'($urandom_range(0, 3));
            rr = {$urandom(), $urandom()};
            v.lat[p] = ($urandom_range(0, 3) == 0) ? 48'd1000 : rr[47:0];
         end
         run_vec(model(v), $sformatf("rnd%0d", r));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
